// File: rtl/des_key_schedule.sv
// DES key schedule: captures a 64-bit key, applies PC-1, then presents the
// sixteen 48-bit round subkeys one per valid/ready handshake, in K1..K16
// order when encrypting and K16..K1 order when decrypting.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] key,
  output logic        busy,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
);

  // PC-1: output bit n (1..56) takes DES key bit PC1_TAB entry n-1.
  // Entry 0 sits in the most significant byte.
  localparam logic [447:0] PC1_TAB = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd28, 8'd20, 8'd12, 8'd4
  };

  // PC-2: subkey bit n (1..48) takes C/D bit PC2_TAB entry n-1.
  localparam logic [383:0] PC2_TAB = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
    8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
    8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
    8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
    8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        mode_reg, mode_next;

  logic [55:0] pc1_cd;
  logic [55:0] cd;
  logic        single_shift;

  // Parity bits (DES bits 8,16,...,64) play no part in the schedule.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  // Circular rotations within one 28-bit half.
  function automatic logic [27:0] rotl1(input logic [27:0] x);
    return {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotl2(input logic [27:0] x);
    return {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr1(input logic [27:0] x);
    return {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotr2(input logic [27:0] x);
    return {x[1:0], x[27:2]};
  endfunction

  // PC-1 wiring; key[63] is DES bit 1.
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      localparam int SRC = int'(PC1_TAB[(55 - gi) * 8 +: 8]);
      assign pc1_cd[55 - gi] = key[64 - SRC];
    end
  endgenerate

  assign cd = {c_reg, d_reg};

  // PC-2 wiring straight off the C/D registers; subkey[47] is PC-2 bit 1.
  generate
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      localparam int SRC = int'(PC2_TAB[(47 - gi) * 8 +: 8]);
      assign subkey[47 - gi] = cd[56 - SRC];
    end
  endgenerate

  // The step after issue count cnt uses s[cnt+2] forward or s[16-cnt]
  // backward; both are single shifts exactly when cnt is 0, 7 or 14.
  assign single_shift = (cnt_reg == 4'd0) || (cnt_reg == 4'd7) ||
                        (cnt_reg == 4'd14);

  // Round index is the true key number, so decrypt counts down from 15.
  assign round = (state_reg == ISSUE) ? (mode_reg ? cnt_reg : ~cnt_reg) : 4'd0;

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    sk_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          cnt_next   = 4'd0;
          // Encrypt starts from CD1; decrypt from CD16, which equals CD0.
          c_next     = mode ? rotl1(pc1_cd[55:28]) : pc1_cd[55:28];
          d_next     = mode ? rotl1(pc1_cd[27:0])  : pc1_cd[27:0];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        sk_valid = 1'b1;
        busy     = 1'b1;
        if (sk_ready) begin
          if (cnt_reg == 4'd15) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 4'd1;
            if (mode_reg) begin
              c_next = single_shift ? rotl1(c_reg) : rotl2(c_reg);
              d_next = single_shift ? rotl1(d_reg) : rotl2(d_reg);
            end else begin
              c_next = single_shift ? rotr1(c_reg) : rotr2(c_reg);
              d_next = single_shift ? rotr1(d_reg) : rotr2(d_reg);
            end
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      c_reg     <= 28'h0;
      d_reg     <= 28'h0;
      cnt_reg   <= 4'd0;
      mode_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

endmodule
